// File: rtl/nes_bus_pkg.sv
// CPU-side bus address map and shared types for the bus initiators.
package nes_bus_pkg;

  localparam logic [15:0] ADDR_PPU_CTRL     = 16'h2000;
  localparam logic [15:0] ADDR_PPU_MASK     = 16'h2001;
  localparam logic [15:0] ADDR_PPU_STATUS   = 16'h2002;
  localparam logic [15:0] ADDR_SPR_RAM_ADDR = 16'h2003;
  localparam logic [15:0] ADDR_SPR_RAM_DATA = 16'h2004;
  localparam logic [15:0] ADDR_PPU_SCROLL   = 16'h2005;
  localparam logic [15:0] ADDR_PPU_ADDR     = 16'h2006;
  localparam logic [15:0] ADDR_PPU_DATA     = 16'h2007;
  localparam logic [15:0] ADDR_SPR_RAM_DMA  = 16'h4014;
  localparam logic [15:0] ADDR_APU_STATUS   = 16'h4015;
  localparam logic [15:0] ADDR_JOYPAD1      = 16'h4016;
  localparam logic [15:0] ADDR_JOYPAD2      = 16'h4017;
  localparam logic [15:0] ADDR_ROM_BASE     = 16'h8000;

  localparam int SPR_XFER_LEN = 256;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

endpackage

// File: rtl/spr_dma_master.sv
// Sprite-RAM DMA bus initiator: halts the CPU and copies one 256-byte page into 2004h.
//
// state     | meaning
// DMA_IDLE  | CPU bus passes straight through to the decoder
// DMA_HALT  | CPU halted, dummy cycle
// DMA_ALIGN | extra dummy cycle so the first read lands on an even cycle
// DMA_READ  | read {page,idx} into dbuf
// DMA_WRITE | write dbuf to 2004h, advance idx or finish
module spr_dma_master
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_SPR_RAM_DMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_SPR_RAM_DATA,
  parameter int          XFER_LEN      = SPR_XFER_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        wen,
  output logic        ren,
  input  logic [7:0]  mem_data_in,
  output logic        dma_busy
);

  localparam int IDX_W = $clog2(XFER_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

  dma_state_t       state, state_next;
  logic [7:0]       page;
  logic [IDX_W-1:0] idx;
  logic [7:0]       dbuf;
  logic             cyc_odd;
  logic             trigger;
  logic [15:0]      src_addr;

  assign trigger     = cpu_wen && (cpu_addr_out == DMA_REG_ADDR);
  // idx never carries into page, so the source stays inside one page
  assign src_addr    = {page, idx};
  assign cpu_data_in = mem_data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DMA_IDLE;
      page    <= '0;
      idx     <= '0;
      dbuf    <= '0;
      cyc_odd <= 1'b0;
    end else begin
      cyc_odd <= ~cyc_odd;
      state   <= state_next;
      if (state == DMA_IDLE && trigger)
        page <= cpu_data_out;
      if (state == DMA_READ)
        dbuf <= mem_data_in;
      if (state == DMA_WRITE)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    addr_out   = cpu_addr_out;
    data_out   = cpu_data_out;
    wen        = cpu_wen;
    ren        = cpu_ren;
    cpu_rdy    = 1'b1;
    dma_busy   = 1'b0;

    case (state)
      DMA_IDLE: begin
        if (trigger)
          state_next = DMA_HALT;
      end
      DMA_HALT, DMA_ALIGN: begin
        addr_out = src_addr;
        data_out = dbuf;
        wen      = 1'b0;
        ren      = 1'b0;
        cpu_rdy  = 1'b0;
        dma_busy = 1'b1;
        // HALT on an odd cycle means the following cycle is already even
        if (state == DMA_HALT && !cyc_odd)
          state_next = DMA_ALIGN;
        else
          state_next = DMA_READ;
      end
      DMA_READ: begin
        addr_out   = src_addr;
        data_out   = dbuf;
        wen        = 1'b0;
        ren        = 1'b1;
        cpu_rdy    = 1'b0;
        dma_busy   = 1'b1;
        state_next = DMA_WRITE;
      end
      DMA_WRITE: begin
        addr_out   = OAM_DATA_ADDR;
        data_out   = dbuf;
        wen        = 1'b1;
        ren        = 1'b0;
        cpu_rdy    = 1'b0;
        dma_busy   = 1'b1;
        state_next = (idx == IDX_LAST) ? DMA_IDLE : DMA_READ;
      end
      default: begin
        state_next = DMA_IDLE;
      end
    endcase
  end

endmodule
